if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Sequencing controller for the instruction fetch stage. It generates the fetch-stage control strobes: single_fetch, no_new_fetch, FREEZE, fetchNull1 and fetchNull2. These are derived from decode consumption, branch outcome, instruction-memory readiness, external stall and pipeline flush. The block sits beside the IF stage and drives its control inputs directly. It also keeps a fetch-stall performance counter and a sticky memory-timeout flag.

Parameters:
BOOT_CYCLES, 2, cycles fetch is held off after reset release (min 1)
FLUSH_CYCLES, 2, cycles both slots are nulled after a flush (min 1)
MISS_TIMEOUT, 64, consecutive not-ready cycles before miss_timeout sets
CNT_W, 16, width of stall_cycles counter

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous active-low reset
imem_ready  input  1  instruction memory returns valid data this cycle
dec_accept  input  2  instructions decode consumed from IF/ID this cycle (0,1,2; 3 treated as 2)
taken_branch1  input  1  branch in slot 1 taken, redirect this cycle
taken_branch2  input  1  branch in slot 2 taken, redirect this cycle
ext_stall  input  1  global pipeline stall request
flush  input  1  exception/flush request, one-cycle pulse
single_fetch  output  1  IF fetches one instruction, reusing buffered slot 2
no_new_fetch  output  1  IF holds PC and IF/ID register
FREEZE  output  1  IF freeze
fetchNull1  output  1  slot 1 loaded as NOP
fetchNull2  output  1  slot 2 loaded as NOP
fetch_state  output  3  current FSM state encoding
miss_timeout  output  1  sticky, memory not ready for MISS_TIMEOUT cycles
stall_cycles  output  CNT_W  saturating count of non-boot stalled cycles

Behaviour:
- Decision: one clock, CLK. RESET is asynchronous and active-low.
- State encoding: BOOT=0, DUAL=1, SINGLE=2, MISS=3, FLUSH=4. 5..7 are unreachable and recover to DUAL on the next edge.
- On reset: state=BOOT, boot/flush/miss counters=0, ret_state=DUAL, miss_timeout=0, stall_cycles=0.
- Reset output values: no_new_fetch=1, fetchNull1=1, fetchNull2=1, single_fetch=0, FREEZE=ext_stall.
- Reset mid-operation aborts any state immediately. No partial state is retained.
- Outputs are combinational decodes of the current state plus the listed inputs:
  - single_fetch = (state==SINGLE).
  - no_new_fetch = state in {BOOT, MISS, FLUSH} OR (state in {DUAL, SINGLE} AND dec_accept==0).
  - FREEZE = ext_stall OR (state==MISS).
  - fetchNull1 = state in {BOOT, FLUSH}.
  - fetchNull2 = fetchNull1 OR (taken_branch1 AND taken_branch2). A simultaneous taken_branch2 is illegal; slot 1 wins and slot 2 is nulled.
- ext_stall freezes all state transitions and counters except stall_cycles and the MISS counter. A flush arriving during ext_stall is still captured.
- Transition priority from DUAL/SINGLE (per edge): flush > !imem_ready > any taken_branch > dec_accept.
  - flush -> FLUSH.
  - !imem_ready -> MISS; ret_state = current state.
  - taken_branch1 or taken_branch2 -> DUAL. This cancels SINGLE, because the buffered slot 2 is stale.
  - dec_accept==1 -> SINGLE.
  - dec_accept==2 -> DUAL.
  - dec_accept==0 -> stay in the current state.
- BOOT: boot counter increments each cycle. When counter==BOOT_CYCLES-1 -> DUAL. flush in BOOT is ignored.
- MISS:
  - The miss counter increments while !imem_ready.
  - When counter reaches MISS_TIMEOUT-1, miss_timeout sets on the next edge and stays set until reset.
  - imem_ready -> ret_state, and the miss counter clears.
  - flush in MISS -> FLUSH; the miss counter clears.
  - A taken branch in MISS is ignored.
- FLUSH: the flush counter counts FLUSH_CYCLES cycles, then -> DUAL. A new flush during FLUSH restarts the counter at 0.
- stall_cycles:
  - +1 on every edge where state!=BOOT and (no_new_fetch OR FREEZE).
  - Saturates at all-ones; no wrap.

Test Plan:
- Reset and boot: release RESET with BOOT_CYCLES=2, imem_ready=1, dec_accept=2 -> 2 cycles with no_new_fetch=1 and fetchNull1/2=1, then fetch_state=1, all nulls 0, stall_cycles=0.
- Single fetch: in DUAL drive dec_accept=1 for one cycle, then 2 -> one cycle of fetch_state=2 with single_fetch=1, then back to 1. Holding dec_accept=1 keeps state 2. dec_accept=0 gives no_new_fetch=1 with the state unchanged.
- Branch cancels single: in SINGLE assert taken_branch2 with dec_accept=1 -> next state DUAL, single_fetch=0. Asserting both taken_branch1 and taken_branch2 -> fetchNull2=1 that cycle only, fetchNull1=0.
- Miss and timeout: from SINGLE drop imem_ready for 70 cycles with MISS_TIMEOUT=64 -> state 3, FREEZE=1, no_new_fetch=1, miss_timeout=1 after 64 cycles. Raising imem_ready returns to state 2, and miss_timeout stays 1.
- Flush priority: in DUAL assert flush, imem_ready=0 and taken_branch1 together -> FLUSH for FLUSH_CYCLES=2 cycles with fetchNull1/2=1. A second flush in cycle 2 extends FLUSH to 3 cycles total, then DUAL.
- Stall counter saturation: CNT_W=4, hold ext_stall=1 for 20 cycles in DUAL -> stall_cycles reaches 15 and holds, state unchanged. Assert RESET mid-run -> all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller: derives IF-stage strobes from decode
// consumption, branch redirects, memory readiness, stalls and flushes.
module if_fetch_ctrl #(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             imem_ready,
  input  logic [1:0]       dec_accept,
  input  logic             taken_branch1,
  input  logic             taken_branch2,
  input  logic             ext_stall,
  input  logic             flush,
  output logic             single_fetch,
  output logic             no_new_fetch,
  output logic             FREEZE,
  output logic             fetchNull1,
  output logic             fetchNull2,
  output logic [2:0]       fetch_state,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int BW = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int MW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

  localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [MW-1:0] MISS_LAST  = MW'(MISS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_DUAL   = 3'd1,
    S_SINGLE = 3'd2,
    S_MISS   = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t          state, state_nx, ret_state, ret_nx;
  logic [BW-1:0]   boot_cnt, boot_nx;
  logic [FW-1:0]   flush_cnt, flush_nx;
  logic [MW-1:0]   miss_cnt, miss_nx;
  logic            flush_pend, pend_nx;
  logic            timeout_nx;
  logic            flush_eff;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= S_BOOT;
      ret_state    <= S_DUAL;
      boot_cnt     <= '0;
      flush_cnt    <= '0;
      miss_cnt     <= '0;
      flush_pend   <= 1'b0;
      miss_timeout <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nx;
      ret_state    <= ret_nx;
      boot_cnt     <= boot_nx;
      flush_cnt    <= flush_nx;
      miss_cnt     <= miss_nx;
      flush_pend   <= pend_nx;
      miss_timeout <= timeout_nx;
      if (state != S_BOOT && (no_new_fetch || FREEZE) && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    single_fetch = (state == S_SINGLE);
    fetchNull1   = (state == S_BOOT) || (state == S_FLUSH);
    fetchNull2   = fetchNull1 || (taken_branch1 && taken_branch2);
    FREEZE       = ext_stall || (state == S_MISS);
    fetch_state  = state;
    case (state)
      S_BOOT, S_MISS, S_FLUSH: no_new_fetch = 1'b1;
      S_DUAL, S_SINGLE:        no_new_fetch = (dec_accept == 2'd0);
      default:                 no_new_fetch = 1'b0;
    endcase
  end

  // A flush seen while stalled is parked and acted on once the stall lifts.
  assign flush_eff = flush || flush_pend;

  always_comb begin
    state_nx   = state;
    ret_nx     = ret_state;
    boot_nx    = boot_cnt;
    flush_nx   = flush_cnt;
    miss_nx    = miss_cnt;
    pend_nx    = flush_pend;
    timeout_nx = miss_timeout;

    // The miss counter keeps running through ext_stall.
    if (state == S_MISS && !imem_ready) begin
      if (miss_cnt == MISS_LAST) timeout_nx = 1'b1;
      else                       miss_nx    = miss_cnt + 1'b1;
    end

    if (ext_stall) begin
      pend_nx = flush_pend || (flush && state != S_BOOT);
    end else begin
      pend_nx = 1'b0;
      case (state)
        S_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state_nx = S_DUAL;
            boot_nx  = '0;
          end else begin
            boot_nx = boot_cnt + 1'b1;
          end
        end
        S_DUAL, S_SINGLE: begin
          if (flush_eff) begin
            state_nx = S_FLUSH;
            flush_nx = '0;
          end else if (!imem_ready) begin
            state_nx = S_MISS;
            ret_nx   = state;
            miss_nx  = '0;
          end else if (taken_branch1 || taken_branch2) begin
            state_nx = S_DUAL;
          end else if (dec_accept == 2'd1) begin
            state_nx = S_SINGLE;
          end else if (dec_accept[1]) begin
            state_nx = S_DUAL;
          end
        end
        S_MISS: begin
          if (flush_eff) begin
            state_nx = S_FLUSH;
            flush_nx = '0;
            miss_nx  = '0;
          end else if (imem_ready) begin
            state_nx = ret_state;
            miss_nx  = '0;
          end
        end
        S_FLUSH: begin
          if (flush_eff) begin
            flush_nx = '0;
          end else if (flush_cnt == FLUSH_LAST) begin
            state_nx = S_DUAL;
            flush_nx = '0;
          end else begin
            flush_nx = flush_cnt + 1'b1;
          end
        end
        default: state_nx = S_DUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a vector table for per-cycle behaviour plus
// hand-written sequences for miss timeout, stall saturation and async reset.
module tb_if_fetch_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       imem_ready;
  logic [1:0] dec_accept;
  logic       taken_branch1, taken_branch2, ext_stall, flush;
  logic       single_fetch, no_new_fetch, FREEZE, fetchNull1, fetchNull2;
  logic [2:0] fetch_state;
  logic       miss_timeout;
  logic [3:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_ctrl #(
    .BOOT_CYCLES(2), .FLUSH_CYCLES(2), .MISS_TIMEOUT(64), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .imem_ready(imem_ready), .dec_accept(dec_accept),
    .taken_branch1(taken_branch1), .taken_branch2(taken_branch2),
    .ext_stall(ext_stall), .flush(flush), .single_fetch(single_fetch),
    .no_new_fetch(no_new_fetch), .FREEZE(FREEZE), .fetchNull1(fetchNull1),
    .fetchNull2(fetchNull2), .fetch_state(fetch_state),
    .miss_timeout(miss_timeout), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ir;
    logic [1:0] da;
    logic       tb1, tb2, es, fl;
    logic [2:0] st;
    logic       sf, nnf, fr, n1, n2;
    logic [3:0] sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [1:0] da, input logic tb1, input logic tb2,
                     input logic es, input logic fl, input logic [2:0] st, input logic sf,
                     input logic nnf, input logic fr, input logic n1, input logic n2,
                     input logic [3:0] sc);
    vec_t v;
    v.ir = ir; v.da = da; v.tb1 = tb1; v.tb2 = tb2; v.es = es; v.fl = fl;
    v.st = st; v.sf = sf; v.nnf = nnf; v.fr = fr; v.n1 = n1; v.n2 = n2; v.sc = sc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [1:0] da, input logic tb1,
                       input logic tb2, input logic es, input logic fl);
    imem_ready = ir; dec_accept = da; taken_branch1 = tb1;
    taken_branch2 = tb2; ext_stall = es; flush = fl;
  endtask

  task automatic check_reset_outputs(input string tag, input logic exp_freeze);
    check({tag, " state"}, 32'(fetch_state), 0);
    check({tag, " no_new_fetch"}, 32'(no_new_fetch), 1);
    check({tag, " fetchNull1"}, 32'(fetchNull1), 1);
    check({tag, " fetchNull2"}, 32'(fetchNull2), 1);
    check({tag, " single_fetch"}, 32'(single_fetch), 0);
    check({tag, " FREEZE"}, 32'(FREEZE), 32'(exp_freeze));
    check({tag, " miss_timeout"}, 32'(miss_timeout), 0);
    check({tag, " stall_cycles"}, 32'(stall_cycles), 0);
  endtask

  initial begin
    //   ir da tb1 tb2 es fl | st sf nnf fr n1 n2 sc
    add(1, 2, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 0);  // boot
    add(1, 2, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // dual -> single
    add(1, 2, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0);  // hold single
    add(1, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0);  // nothing consumed
    add(1, 1, 0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 1);  // branch cancels single
    add(1, 2, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // both branches: null slot 2
    add(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1);
    add(1, 2, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 2);  // ext_stall freezes
    add(1, 1, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 3);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 4);  // miss from single
    add(0, 1, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0, 4);
    add(1, 2, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0, 5);  // return to single
    add(1, 2, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0, 6);
    add(0, 2, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 6);  // flush beats miss/branch
    add(1, 2, 0, 0, 0, 1,  4, 0, 1, 0, 1, 1, 6);  // re-flush restarts
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 7);
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 8);
    add(1, 2, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 9);  // plain flush
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 9);
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 10);
    add(1, 2, 0, 0, 1, 1,  1, 0, 0, 1, 0, 0, 11); // flush under stall captured
    add(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 12);
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 12);
    add(1, 2, 0, 0, 0, 0,  4, 0, 1, 0, 1, 1, 13);
    add(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 14);

    RESET = 1'b0;
    drive(1, 2, 0, 0, 0, 0);
    #7;
    check_reset_outputs("init_reset", 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].da, vecs[i].tb1, vecs[i].tb2, vecs[i].es, vecs[i].fl);
      #1;
      check($sformatf("v%0d state", i), 32'(fetch_state), 32'(vecs[i].st));
      check($sformatf("v%0d single_fetch", i), 32'(single_fetch), 32'(vecs[i].sf));
      check($sformatf("v%0d no_new_fetch", i), 32'(no_new_fetch), 32'(vecs[i].nnf));
      check($sformatf("v%0d FREEZE", i), 32'(FREEZE), 32'(vecs[i].fr));
      check($sformatf("v%0d fetchNull1", i), 32'(fetchNull1), 32'(vecs[i].n1));
      check($sformatf("v%0d fetchNull2", i), 32'(fetchNull2), 32'(vecs[i].n2));
      check($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), 32'(vecs[i].sc));
      @(negedge CLK);
    end

    // Miss with timeout, entered from SINGLE
    drive(1, 1, 0, 0, 0, 0);
    @(negedge CLK); #1;
    check("miss_pre state", 32'(fetch_state), 2);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      @(negedge CLK); #1;
      if (i == 1) begin
        check("miss state", 32'(fetch_state), 3);
        check("miss FREEZE", 32'(FREEZE), 1);
        check("miss no_new_fetch", 32'(no_new_fetch), 1);
      end
      if (i == 64) check("miss_timeout early", 32'(miss_timeout), 0);
      if (i == 65) check("miss_timeout set", 32'(miss_timeout), 1);
      if (i == 70) check("miss state held", 32'(fetch_state), 3);
    end
    drive(1, 1, 0, 0, 0, 0);
    #1;
    check("miss exit pre", 32'(fetch_state), 3);
    @(negedge CLK); #1;
    check("miss return state", 32'(fetch_state), 2);
    check("miss return single_fetch", 32'(single_fetch), 1);
    check("miss_timeout sticky", 32'(miss_timeout), 1);

    // Asynchronous reset mid-cycle
    #2 RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset1", 1'b0);
    drive(1, 2, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK); #1;
    check("reboot state c1", 32'(fetch_state), 0);
    @(negedge CLK); #1;
    check("reboot state c2", 32'(fetch_state), 1);
    check("reboot stall_cycles", 32'(stall_cycles), 0);

    // Stall counter saturation in DUAL
    drive(1, 2, 0, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK); #1;
      if (i == 14) check("sat stall_cycles 14", 32'(stall_cycles), 14);
      if (i == 15) check("sat stall_cycles 15", 32'(stall_cycles), 15);
      if (i == 20) begin
        check("sat stall_cycles held", 32'(stall_cycles), 15);
        check("sat state", 32'(fetch_state), 1);
        check("sat FREEZE", 32'(FREEZE), 1);
      end
    end

    #2 RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset2", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
